// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared LC-3b types for the instruction/data memory arbiter.
//   lc3b_word       : 16-bit address/data word
//   lc3b_mem_wmask  : per-byte write mask for one word
//   lc3b_arb_state  : arbiter grant state
//   LAST_I / LAST_D : encoding of the most recently served port (round-robin)
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_mem_wmask;

    typedef enum logic [1:0] {
        arb_idle    = 2'b00,
        arb_grant_i = 2'b01,
        arb_grant_d = 2'b10
    } lc3b_arb_state;

    localparam logic LAST_I = 1'b0;
    localparam logic LAST_D = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// -----------------------------------------------------------------------------
// mem_arb_pick
// Combinational arbitration policy between the instruction and data ports.
// At most one grant is ever high.
//   Build option: MEM_ARB_RR_EN
//     defined   : on a tie the port that was not served last wins
//     undefined : data always beats instruction; last_grant is ignored
// Ports:
//   i_req      in  instruction port requesting
//   d_req      in  data port requesting (read or write)
//   last_grant in  port served most recently (LAST_I / LAST_D)
//   grant_i    out instruction port wins
//   grant_d    out data port wins
// -----------------------------------------------------------------------------
module mem_arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic i_req,
    input  logic d_req,
    input  logic last_grant,
    output logic grant_i,
    output logic grant_d
);

`ifdef MEM_ARB_RR_EN
    // Round-robin on ties, lone requests always granted.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (i_req && d_req) begin
            grant_d = (last_grant == LAST_I);
            grant_i = (last_grant == LAST_D);
        end else begin
            grant_i = i_req;
            grant_d = d_req;
        end
    end
`else
    logic w_unused_last_grant;
    assign w_unused_last_grant = last_grant;

    // Fixed priority: data over instruction.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (d_req) begin
            grant_d = 1'b1;
        end else begin
            grant_i = i_req;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one physical memory port between the LC-3b instruction-fetch and
// data (load/store) ports. All three sides use a request-held-until-resp
// handshake. The winner's request is latched into output registers, held
// until pmem_resp, and every completion is followed by one IDLE cycle so a
// requester dropping its request after resp is never served twice.
//   Build option: MEM_ARB_RR_EN (round-robin on ties, see mem_arb_pick)
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   i_read, i_address                instruction request
//   i_rdata, i_resp                  instruction data / completion pulse
//   d_read, d_write, d_address,
//   d_wdata, d_byte_enable           data request (read+write = write)
//   d_rdata, d_resp                  load data / completion pulse
//   pmem_read, pmem_write,
//   pmem_address, pmem_wdata,
//   pmem_byte_enable                 registered physical request
//   pmem_rdata, pmem_resp            physical read data / completion
//   busy                             a transaction is granted
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter  int ADDR_W = $bits(lc3b_word),
    parameter  int DATA_W = $bits(lc3b_word),
    localparam int MASK_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [MASK_W-1:0] d_byte_enable,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [DATA_W-1:0] pmem_wdata,
    output logic [MASK_W-1:0] pmem_byte_enable,
    input  logic [DATA_W-1:0] pmem_rdata,
    input  logic              pmem_resp,
    output logic              busy
);

    lc3b_arb_state     r_state;
    logic              r_pmem_read;
    logic              r_pmem_write;
    logic [ADDR_W-1:0] r_pmem_address;
    logic [DATA_W-1:0] r_pmem_wdata;
    logic [MASK_W-1:0] r_pmem_byte_enable;
    logic              r_busy;

    logic w_i_req;
    logic w_d_req;
    logic w_grant_i;
    logic w_grant_d;
    logic w_last_grant;

    assign w_i_req = i_read;
    assign w_d_req = d_read | d_write;

`ifdef MEM_ARB_RR_EN
    logic r_last_grant;

    // Remember which port won the last IDLE decision so the next tie alternates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= LAST_I;
        end else if ((r_state == arb_idle) && w_grant_d) begin
            r_last_grant <= LAST_D;
        end else if ((r_state == arb_idle) && w_grant_i) begin
            r_last_grant <= LAST_I;
        end else begin
            r_last_grant <= r_last_grant;
        end
    end

    assign w_last_grant = r_last_grant;
`else
    assign w_last_grant = LAST_I;
`endif

    mem_arb_pick u_pick (
        .i_req      (w_i_req),
        .d_req      (w_d_req),
        .last_grant (w_last_grant),
        .grant_i    (w_grant_i),
        .grant_d    (w_grant_d)
    );

    // Grant FSM: latch the winner in IDLE, hold the request until pmem_resp.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state            <= arb_idle;
            r_pmem_read        <= 1'b0;
            r_pmem_write       <= 1'b0;
            r_pmem_address     <= '0;
            r_pmem_wdata       <= '0;
            r_pmem_byte_enable <= '1;
            r_busy             <= 1'b0;
        end else begin
            case (r_state)
                arb_idle: begin
                    if (w_grant_d) begin
                        // read+write together is treated as a write
                        r_state            <= arb_grant_d;
                        r_pmem_write       <= d_write;
                        r_pmem_read        <= d_read & ~d_write;
                        r_pmem_address     <= d_address;
                        r_pmem_wdata       <= d_wdata;
                        r_pmem_byte_enable <= d_byte_enable;
                        r_busy             <= 1'b1;
                    end else if (w_grant_i) begin
                        r_state            <= arb_grant_i;
                        r_pmem_write       <= 1'b0;
                        r_pmem_read        <= 1'b1;
                        r_pmem_address     <= i_address;
                        r_pmem_wdata       <= '0;
                        r_pmem_byte_enable <= '1;
                        r_busy             <= 1'b1;
                    end else begin
                        // a stray pmem_resp here is simply ignored
                        r_state <= arb_idle;
                    end
                end
                arb_grant_i, arb_grant_d: begin
                    if (pmem_resp) begin
                        r_state      <= arb_idle;
                        r_pmem_read  <= 1'b0;
                        r_pmem_write <= 1'b0;
                        r_busy       <= 1'b0;
                    end else begin
                        r_state <= r_state;
                    end
                end
                default: begin
                    r_state      <= arb_idle;
                    r_pmem_read  <= 1'b0;
                    r_pmem_write <= 1'b0;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    assign pmem_read        = r_pmem_read;
    assign pmem_write       = r_pmem_write;
    assign pmem_address     = r_pmem_address;
    assign pmem_wdata       = r_pmem_wdata;
    assign pmem_byte_enable = r_pmem_byte_enable;
    assign busy             = r_busy;

    // Completion is steered combinationally so the requester sees it in the
    // same cycle as pmem_resp; read data is broadcast to both ports.
    assign i_resp  = (r_state == arb_grant_i) && pmem_resp;
    assign d_resp  = (r_state == arb_grant_d) && pmem_resp;
    assign i_rdata = pmem_rdata;
    assign d_rdata = pmem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Requester tasks push expected responses into per-port queues; a monitor pops
// and compares on every resp pulse. A behavioural physical memory answers with
// programmable latency and checks each pmem request against the requester that
// owns its address region (I: 0x00xx, D: 0x01xx).
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_read = 1'b0;
    logic [15:0] i_address = 16'h0000;
    logic [15:0] i_rdata;
    logic        i_resp;
    logic        d_read = 1'b0;
    logic        d_write = 1'b0;
    logic [15:0] d_address = 16'h0000;
    logic [15:0] d_wdata = 16'h0000;
    logic [1:0]  d_byte_enable = 2'b11;
    logic [15:0] d_rdata;
    logic        d_resp;
    logic        pmem_read;
    logic        pmem_write;
    logic [15:0] pmem_address;
    logic [15:0] pmem_wdata;
    logic [1:0]  pmem_byte_enable;
    logic [15:0] pmem_rdata = 16'h0000;
    logic        pmem_resp = 1'b0;
    logic        busy;

    mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_byte_enable(d_byte_enable), .d_rdata(d_rdata), .d_resp(d_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_byte_enable(pmem_byte_enable),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp), .busy(busy)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference memory (what requesters expect) -------------
    function automatic logic [15:0] init_word(input logic [15:0] a);
        return (a * 16'h9E37) ^ 16'h5A5A;
    endfunction

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] wd,
                                          input logic [1:0] be);
        logic [15:0] m;
        m = {{8{be[1]}}, {8{be[0]}}};
        return (old & ~m) | (wd & m);
    endfunction

    logic [15:0] ref_mem  [logic [15:0]];
    logic [15:0] pmem_mem [logic [15:0]];

    function automatic logic [15:0] ref_get(input logic [15:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    function automatic logic [15:0] phys_get(input logic [15:0] a);
        return pmem_mem.exists(a) ? pmem_mem[a] : init_word(a);
    endfunction

    typedef struct packed { logic wr; logic [15:0] data; } exp_t;
    exp_t iq[$];
    exp_t dq[$];
    int   served[$];
    int   resp_cyc[$];
    int   start_cyc[$];

    // current outstanding request of each port
    bit          i_act = 1'b0;
    logic [15:0] i_cur_addr = 16'h0000;
    bit          d_act = 1'b0;
    bit          d_cur_wr = 1'b0;
    logic [15:0] d_cur_addr = 16'h0000;
    logic [15:0] d_cur_wdata = 16'h0000;
    logic [1:0]  d_cur_be = 2'b11;

    int mem_lat = 3;          // <0 selects a random latency per transaction
    bit late_resp = 1'b0;     // drive one unsolicited pmem_resp
    int last_resp_cyc = -10;

    // ---------------- physical memory model ----------------------------------
    initial begin
        int cnt;
        int lat;
        bit active;
        logic [35:0] cap;
        cnt = 0; lat = 0; active = 1'b0; cap = '0;
        forever begin
            @(posedge clk);
            #1;
            if (pmem_resp) begin
                pmem_resp  = 1'b0;
                active     = 1'b0;
                pmem_rdata = 16'($urandom);
            end else if (late_resp) begin
                late_resp  = 1'b0;
                pmem_resp  = 1'b1;
                pmem_rdata = 16'($urandom);
            end else if (rst_n && (pmem_read || pmem_write)) begin
                if (!active) begin
                    active = 1'b1;
                    cnt    = 0;
                    lat    = (mem_lat < 0) ? int'($urandom_range(0, 3)) : mem_lat;
                    cap    = {pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_byte_enable};
                    start_cyc.push_back(cyc);
                    check("pmem_one_op", 64'(pmem_read & pmem_write), 64'd0);
                    check("idle_gap", 64'((cyc - last_resp_cyc) >= 2), 64'd1);
                    if (!pmem_address[8]) begin
                        check("pmem_i_owner", 64'(i_act), 64'd1);
                        check("pmem_i_op", 64'({pmem_read, pmem_write}), 64'd2);
                        check("pmem_i_addr", 64'(pmem_address), 64'(i_cur_addr));
                    end else begin
                        check("pmem_d_owner", 64'(d_act), 64'd1);
                        check("pmem_d_op", 64'({pmem_read, pmem_write}), d_cur_wr ? 64'd1 : 64'd2);
                        check("pmem_d_addr", 64'(pmem_address), 64'(d_cur_addr));
                        if (d_cur_wr) begin
                            check("pmem_wdata", 64'(pmem_wdata), 64'(d_cur_wdata));
                            check("pmem_be", 64'(pmem_byte_enable), 64'(d_cur_be));
                        end
                    end
                end else begin
                    check("pmem_hold",
                          64'({pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_byte_enable}),
                          64'(cap));
                end
                if (cnt >= lat) begin
                    if (pmem_write)
                        pmem_mem[pmem_address] = merge(phys_get(pmem_address), pmem_wdata,
                                                       pmem_byte_enable);
                    pmem_rdata    = phys_get(pmem_address);
                    pmem_resp     = 1'b1;
                    last_resp_cyc = cyc;
                end
                cnt++;
            end else begin
                active = 1'b0;
            end
        end
    end

    // ---------------- response monitor / scoreboard --------------------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (i_resp || d_resp)
                check("resp_onehot", 64'(i_resp & d_resp), 64'd0);
            if (i_resp) begin
                check("i_resp_pending", 64'(iq.size() != 0), 64'd1);
                check("i_rdata_bcast", 64'(i_rdata), 64'(pmem_rdata));
                if (iq.size() != 0) begin
                    e = iq.pop_front();
                    check("i_rdata", 64'(i_rdata), 64'(e.data));
                    served.push_back(0);
                    resp_cyc.push_back(cyc);
                end
            end
            if (d_resp) begin
                check("d_resp_pending", 64'(dq.size() != 0), 64'd1);
                check("d_rdata_bcast", 64'(d_rdata), 64'(pmem_rdata));
                if (dq.size() != 0) begin
                    e = dq.pop_front();
                    if (!e.wr) check("d_rdata", 64'(d_rdata), 64'(e.data));
                    served.push_back(1);
                    resp_cyc.push_back(cyc);
                end
            end
        end
    end

    // ---------------- requesters (called at a negedge) -----------------------
    task automatic do_i(input logic [15:0] a, input bit chk);
        exp_t e;
        bit got;
        e.wr = 1'b0;
        e.data = ref_get(a);
        iq.push_back(e);
        i_cur_addr = a; i_act = 1'b1;
        i_address = a; i_read = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            if (chk && k == 0) begin
                check("lat_i_pmem_read", 64'(pmem_read), 64'd1);
                check("lat_i_addr", 64'(pmem_address), 64'(a));
                check("lat_i_busy", 64'(busy), 64'd1);
            end
            if (i_resp) got = 1'b1;
        end
        check("i_timeout", 64'(got), 64'd1);
        if (!got) iq.delete();
        @(posedge clk);
        #1;
        i_read = 1'b0; i_act = 1'b0;
        @(negedge clk);
        check("i_post_idle", 64'({pmem_read, pmem_write, busy}), 64'd0);
    endtask

    task automatic do_d(input bit wr, input bit both, input logic [15:0] a,
                        input logic [15:0] wd, input logic [1:0] be, input bit chk);
        exp_t e;
        bit got;
        e.wr = wr;
        e.data = ref_get(a);
        if (wr) ref_mem[a] = merge(ref_get(a), wd, be);
        dq.push_back(e);
        d_cur_wr = wr; d_cur_addr = a; d_cur_wdata = wd; d_cur_be = be; d_act = 1'b1;
        d_address = a; d_wdata = wd; d_byte_enable = be;
        d_write = wr; d_read = !wr || both;
        got = 1'b0;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            if (chk && k == 0) begin
                check("lat_d_pmem_write", 64'({pmem_read, pmem_write}), wr ? 64'd1 : 64'd2);
                check("lat_d_busy", 64'(busy), 64'd1);
            end
            if (d_resp) got = 1'b1;
        end
        check("d_timeout", 64'(got), 64'd1);
        if (!got) dq.delete();
        @(posedge clk);
        #1;
        d_read = 1'b0; d_write = 1'b0; d_act = 1'b0;
        @(negedge clk);
        check("d_post_idle", 64'({pmem_read, pmem_write, busy}), 64'd0);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        i_act = 1'b0; d_act = 1'b0;
        iq.delete(); dq.delete();
        repeat (3) @(negedge clk);
        check("rst_pmem_op", 64'({pmem_read, pmem_write}), 64'd0);
        check("rst_pmem_addr", 64'(pmem_address), 64'd0);
        check("rst_pmem_wdata", 64'(pmem_wdata), 64'd0);
        check("rst_pmem_be", 64'(pmem_byte_enable), 64'd3);
        check("rst_resp_busy", 64'({i_resp, d_resp, busy}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence -----------------------------------------
    initial begin
        int exp_order [3];
        apply_reset();

        // stray pmem_resp while idle
        @(posedge clk);
        late_resp = 1'b1;
        @(negedge clk);
        check("stray_resp", 64'({i_resp, d_resp, busy}), 64'd0);
        @(negedge clk);

        // lone instruction read, memory answers 0x1234 after 3 cycles
        mem_lat = 3;
        pmem_mem[16'h0040] = 16'h1234;
        ref_mem[16'h0040]  = 16'h1234;
        do_i(16'h0040, 1'b1);

        // lone store then read back
        do_d(1'b1, 1'b0, 16'h0102, 16'hBEEF, 2'b01, 1'b1);
        do_d(1'b0, 1'b0, 16'h0102, 16'h0000, 2'b11, 1'b1);

        // ties: D re-requests right after its completion while I waits
        apply_reset();
        mem_lat = 1;
        served.delete(); resp_cyc.delete(); start_cyc.delete();
        fork
            begin
                do_d(1'b0, 1'b0, 16'h0110, 16'h0000, 2'b11, 1'b0);
                do_d(1'b1, 1'b0, 16'h0112, 16'hA5A5, 2'b10, 1'b0);
            end
            do_i(16'h0020, 1'b0);
        join
`ifdef MEM_ARB_RR_EN
        exp_order = '{1, 0, 1};
`else
        exp_order = '{1, 1, 0};
`endif
        check("tie_count", 64'(served.size()), 64'd3);
        if (served.size() >= 3 && start_cyc.size() >= 3) begin
            for (int n = 0; n < 3; n++) check("tie_order", 64'(served[n]), 64'(exp_order[n]));
            check("tie_gap1", 64'(start_cyc[1]), 64'(resp_cyc[0] + 2));
            check("tie_gap2", 64'(start_cyc[2]), 64'(resp_cyc[1] + 2));
        end

        // random traffic on both ports
        mem_lat = -1;
        fork
            begin
                for (int n = 0; n < 40; n++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    do_i({8'h00, 8'($urandom)}, 1'b0);
                end
            end
            begin
                for (int n = 0; n < 60; n++) begin
                    bit wr;
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    wr = 1'($urandom_range(0, 1));
                    do_d(wr, wr && ($urandom_range(0, 7) == 0),
                         16'h0100 | 16'($urandom_range(0, 31)),
                         16'($urandom), 2'($urandom_range(0, 3)), 1'b0);
                end
            end
        join
        for (int a = 16'h0100; a < 16'h0120; a++)
            check("mem_final", 64'(phys_get(16'(a))), 64'(ref_get(16'(a))));

        // reset in the middle of a store, then a late pmem_resp
        mem_lat = 20;
        d_cur_wr = 1'b1; d_cur_addr = 16'h0104; d_cur_wdata = 16'h1111; d_cur_be = 2'b11;
        d_act = 1'b1;
        d_address = 16'h0104; d_wdata = 16'h1111; d_byte_enable = 2'b11;
        d_write = 1'b1; d_read = 1'b0;
        for (int k = 0; k < 10 && !pmem_write; k++) @(negedge clk);
        check("rst_setup_grant", 64'(pmem_write), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_write", 64'({pmem_read, pmem_write}), 64'd0);
        check("rst_async_busy", 64'(busy), 64'd0);
        check("rst_async_addr", 64'(pmem_address), 64'd0);
        d_write = 1'b0; d_act = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        late_resp = 1'b1;
        @(negedge clk);
        check("late_resp_ignored", 64'({i_resp, d_resp, busy}), 64'd0);
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
